// File: rtl/glyph_row_fetcher.sv
// ============================================================================
// Module  : glyph_row_fetcher
// Brief   : Fetches one 8-pixel glyph row from a 1-bit wishbone ROM, with a
//           one-entry {char,row} cache that bypasses the ROM on repeats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module glyph_row_fetcher #(
  parameter int CHAR_W  = 7,
  parameter int ROW_W   = 4,
  parameter int COL_W   = 3,
  localparam int GLYPH_W = 1 << COL_W,
  localparam int ADDR_W  = CHAR_W + ROW_W + COL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [CHAR_W-1:0]  i_req_char,
  input  logic [ROW_W-1:0]   i_req_row,
  input  logic               i_flush,
  output logic               o_row_valid,
  input  logic               i_row_ready,
  output logic [GLYPH_W-1:0] o_row_data,
  output logic               o_wb_stb,
  output logic [ADDR_W-1:0]  o_wb_addr,
  input  logic               i_wb_ack,
  input  logic               i_wb_stall,
  input  logic               i_wb_data,
  output logic               o_err
);

  localparam int CNT_W = COL_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic               r_ready_en;
  logic [CHAR_W-1:0]  r_char;
  logic [ROW_W-1:0]   r_row;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic [CNT_W-1:0]   r_ack_cnt;
  logic [GLYPH_W-1:0] r_shift;
  logic [GLYPH_W-1:0] r_row_data;
  logic               r_cache_valid;
  logic [CHAR_W-1:0]  r_cache_char;
  logic [ROW_W-1:0]   r_cache_row;
  logic [GLYPH_W-1:0] r_cache_data;
  logic               r_err;

  logic               w_accept;
  logic               w_hit;
  logic [CNT_W-1:0]   w_outstanding;
  logic               w_ack_ok;
  logic               w_last_ack;
  logic               w_issue;
  logic [GLYPH_W-1:0] w_row_next;

  assign w_accept      = i_req_valid && o_req_ready;
  assign w_hit         = r_cache_valid && !i_flush &&
                         (i_req_char == r_cache_char) && (i_req_row == r_cache_row);
  assign w_outstanding = r_issue_cnt - r_ack_cnt;
  // An ack with nothing outstanding (including leftovers from before a reset) is stray.
  assign w_ack_ok      = i_wb_ack && (w_outstanding != '0);
  assign w_last_ack    = w_ack_ok && !r_ack_cnt[COL_W] && (&r_ack_cnt[COL_W-1:0]);
  assign w_issue       = o_wb_stb && !i_wb_stall;
  assign w_row_next    = {r_shift[GLYPH_W-2:0], i_wb_data};

  assign o_wb_addr  = {r_char, r_row, r_issue_cnt[COL_W-1:0]};
  assign o_row_data = r_row_data;
  assign o_err      = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_ready_en <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_next_state = w_hit ? S_DONE : S_FETCH;
      S_FETCH: if (w_last_ack)  w_next_state = S_DONE;
      S_DONE:  if (i_row_ready) w_next_state = S_IDLE;
      default:                  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = 1'b0;
    o_wb_stb    = 1'b0;
    o_row_valid = 1'b0;
    case (r_state)
      S_IDLE:  o_req_ready = r_ready_en;
      S_FETCH: o_wb_stb    = !r_issue_cnt[COL_W];
      S_DONE:  o_row_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_char      <= '0;
      r_row       <= '0;
      r_issue_cnt <= '0;
      r_ack_cnt   <= '0;
      r_shift     <= '0;
      r_row_data  <= '0;
    end else begin
      if (w_accept) begin
        r_char      <= i_req_char;
        r_row       <= i_req_row;
        r_issue_cnt <= '0;
        r_ack_cnt   <= '0;
        if (w_hit) r_row_data <= r_cache_data;
      end else begin
        if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
        if (w_ack_ok) begin
          r_ack_cnt <= r_ack_cnt + 1'b1;
          r_shift   <= w_row_next;
        end
        if (w_last_ack) r_row_data <= w_row_next;
      end
    end
  end

  // A flush coinciding with the final ack still lets the row through but leaves it uncached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_valid <= 1'b0;
      r_cache_char  <= '0;
      r_cache_row   <= '0;
      r_cache_data  <= '0;
    end else if (w_last_ack) begin
      r_cache_valid <= !i_flush;
      r_cache_char  <= r_char;
      r_cache_row   <= r_row;
      r_cache_data  <= w_row_next;
    end else if (i_flush) begin
      r_cache_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (i_wb_ack && (w_outstanding == '0)) begin
      r_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_glyph_row_fetcher.sv
// ============================================================================
// Module  : tb_glyph_row_fetcher
// Brief   : Scoreboard bench for glyph_row_fetcher with a 1-cycle-ack ROM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_glyph_row_fetcher;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic [6:0]    i_req_char = '0;
  logic [3:0]    i_req_row = '0;
  logic          i_flush = 1'b0;
  logic          o_row_valid;
  logic          i_row_ready = 1'b1;
  logic [7:0]    o_row_data;
  logic          o_wb_stb;
  logic [AW-1:0] o_wb_addr;
  logic          i_wb_ack;
  logic          i_wb_stall = 1'b0;
  logic          i_wb_data;
  logic          o_err;

  logic          r_rom_ack;
  logic          r_rom_data;
  logic          stray_ack = 1'b0;

  int            n_cmp = 0;
  int            n_err = 0;
  int            stb_cnt = 0;
  logic [7:0]    exp_q[$];
  logic [AW-1:0] stb_q[$];

  always #5 clk = ~clk;

  glyph_row_fetcher dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_char(i_req_char), .i_req_row(i_req_row), .i_flush(i_flush),
    .o_row_valid(o_row_valid), .i_row_ready(i_row_ready), .o_row_data(o_row_data),
    .o_wb_stb(o_wb_stb), .o_wb_addr(o_wb_addr), .i_wb_ack(i_wb_ack),
    .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data), .o_err(o_err)
  );

  function automatic logic [7:0] glyph(input logic [6:0] c, input logic [3:0] r);
    if (c == 7'h41 && r == 4'd5) return 8'h18;
    return (8'(c) * 8'd37) ^ (8'(r) * 8'd91) ^ 8'h5A;
  endfunction

  function automatic logic rom_bit(input logic [AW-1:0] a);
    logic [7:0] g;
    g = glyph(a[13:7], a[6:3]);
    return g[3'd7 - a[2:0]];
  endfunction

  // ROM: acks every accepted strobe exactly one cycle later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_ack  <= 1'b0;
      r_rom_data <= 1'b0;
    end else begin
      r_rom_ack  <= o_wb_stb && !i_wb_stall;
      r_rom_data <= rom_bit(o_wb_addr);
    end
  end
  assign i_wb_ack  = r_rom_ack | stray_ack;
  assign i_wb_data = r_rom_data;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_wb_stb && !i_wb_stall) begin
        stb_q.push_back(o_wb_addr);
        stb_cnt++;
      end
      if (o_row_valid && i_row_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL row_unexpected actual=%h required=none", o_row_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (o_row_data !== e) begin
            n_err++;
            $display("FAIL row_data actual=%h required=%h", o_row_data, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [6:0] c, input logic [3:0] r);
    logic rdy;
    bit   done;
    done = 0;
    i_req_valid = 1'b1;
    i_req_char  = c;
    i_req_row   = r;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      rdy = o_req_ready;
      if (rdy) exp_q.push_back(glyph(c, r));
      tick();
      if (rdy) done = 1;
    end
    i_req_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL req_accept_timeout actual=never required=accepted");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({o_req_ready, o_row_valid, o_wb_stb, o_err} !== 4'b0000 || o_row_data !== 8'h00 || o_wb_addr !== '0) begin
      n_err++;
      $display("FAIL reset_outputs actual=rdy%b vld%b stb%b err%b d%h a%h required=all zero",
               o_req_ready, o_row_valid, o_wb_stb, o_err, o_row_data, o_wb_addr);
    end
    tick(); tick();
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (o_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset actual=%b required=1", o_req_ready);
    end
    // assert reset in the middle of a fetch
    tick();
    send(7'h10, 4'd3);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_wb_stb, o_row_valid, o_req_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_midfetch actual=stb%b vld%b rdy%b required=000", o_wb_stb, o_row_valid, o_req_ready);
    end
    exp_q.delete();
    tick(); tick(); tick();
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (o_req_ready !== 1'b1 || o_err !== 1'b0) begin
      n_err++;
      $display("FAIL ready_after_midreset actual=rdy%b err%b required=rdy1 err0", o_req_ready, o_err);
    end
    tick();
  endtask

  task automatic test_miss();
    logic [11:0] stb_v, vld_v;
    logic [7:0]  d10;
    stb_v = '0; vld_v = '0; d10 = '0;
    stb_q.delete();
    send(7'h41, 4'd5);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      stb_v[k] = o_wb_stb;
      vld_v[k] = o_row_valid;
      if (k == 10) d10 = o_row_data;
    end
    n_cmp++;
    if (stb_v !== 12'h1FE) begin
      n_err++;
      $display("FAIL miss_stb_cycles actual=%h required=1fe", stb_v);
    end
    n_cmp++;
    if (vld_v !== 12'h400) begin
      n_err++;
      $display("FAIL miss_valid_cycle actual=%h required=400", vld_v);
    end
    n_cmp++;
    if (d10 !== 8'h18) begin
      n_err++;
      $display("FAIL miss_data actual=%h required=18", d10);
    end
    n_cmp++;
    if (stb_q.size() != 8) begin
      n_err++;
      $display("FAIL miss_stb_count actual=%0d required=8", stb_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (stb_q[i] !== {7'h41, 4'd5, 3'(i)}) begin
          n_err++;
          $display("FAIL miss_addr actual=%h required=%h", stb_q[i], {7'h41, 4'd5, 3'(i)});
        end
      end
    end
    wait_drain();
  endtask

  task automatic test_hit();
    int c0;
    tick();
    c0 = stb_cnt;
    send(7'h41, 4'd5);
    @(negedge clk);
    n_cmp++;
    if (o_row_valid !== 1'b1 || o_row_data !== 8'h18) begin
      n_err++;
      $display("FAIL hit_next_cycle actual=vld%b d%h required=vld1 d18", o_row_valid, o_row_data);
    end
    wait_drain();
    tick(); tick();
    n_cmp++;
    if (stb_cnt != c0) begin
      n_err++;
      $display("FAIL hit_strobes actual=%0d required=0", stb_cnt - c0);
    end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    c0 = stb_cnt;
    send(7'h41, 4'd5);
    wait_drain();
    n_cmp++;
    if (stb_cnt - c0 != 8) begin
      n_err++;
      $display("FAIL flush_refetch_strobes actual=%0d required=8", stb_cnt - c0);
    end
  endtask

  task automatic test_stall();
    tick();
    stb_q.delete();
    send(7'h2C, 4'd9);
    tick();
    i_wb_stall = 1'b1;
    tick(); tick(); tick();
    i_wb_stall = 1'b0;
    wait_drain();
    n_cmp++;
    if (stb_q.size() != 8) begin
      n_err++;
      $display("FAIL stall_stb_count actual=%0d required=8", stb_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (stb_q[i] !== {7'h2C, 4'd9, 3'(i)}) begin
          n_err++;
          $display("FAIL stall_addr actual=%h required=%h", stb_q[i], {7'h2C, 4'd9, 3'(i)});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      send(7'(8'h50 + 8'(3 * i)), 4'(i + 2));
      wait_drain();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d0;
    int         c0, n;
    bit         held;
    tick();
    i_row_ready = 1'b0;
    send(7'h33, 4'd2);
    n = 0;
    while (o_row_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    @(negedge clk);
    d0 = o_row_data;
    n_cmp++;
    if (o_row_valid !== 1'b1 || d0 !== glyph(7'h33, 4'd2)) begin
      n_err++;
      $display("FAIL bp_row actual=vld%b d%h required=vld1 d%h", o_row_valid, d0, glyph(7'h33, 4'd2));
    end
    c0 = stb_cnt;
    held = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_row_valid !== 1'b1 || o_row_data !== d0 || o_req_ready !== 1'b0) held = 0;
    end
    n_cmp++;
    if (!held) begin
      n_err++;
      $display("FAIL bp_hold actual=changed required=held vld/data, ready=0");
    end
    n_cmp++;
    if (stb_cnt != c0) begin
      n_err++;
      $display("FAIL bp_strobes actual=%0d required=0", stb_cnt - c0);
    end
    tick();
    i_row_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_stray();
    tick();
    n_cmp++;
    if (o_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_before_stray actual=%b required=0", o_err);
    end
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_err !== 1'b1) begin
      n_err++;
      $display("FAIL stray_err actual=%b required=1", o_err);
    end
    tick();
    send(7'h41, 4'd6);
    wait_drain();
    @(negedge clk);
    n_cmp++;
    if (o_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky actual=%b required=1", o_err);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_stall();
    test_back_to_back();
    test_backpressure();
    test_stray();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
